// File: rtl/pc_unit.sv
// Program counter for the single-cycle MIPS core: next-PC selection, EPC capture
// and a circular return-address stack that checks `jr $ra` targets.
module pc_unit #(
    parameter int unsigned          N_BITS       = 32,
    parameter logic [N_BITS-1:0]    RESET_VECTOR = N_BITS'(32'h0040_0000),
    parameter logic [N_BITS-1:0]    EXC_VECTOR   = N_BITS'(32'h8000_0180),
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall_i,
    input  logic                             branch_taken_i,
    input  logic [15:0]                      branch_offset_i,
    input  logic                             jump_i,
    input  logic [25:0]                      jump_target_i,
    input  logic                             jr_i,
    input  logic [N_BITS-1:0]                jr_addr_i,
    input  logic                             call_i,
    input  logic                             ret_i,
    input  logic                             exception_i,
    output logic [N_BITS-1:0]                pc_value_o,
    output logic [N_BITS-1:0]                pc_plus4_o,
    output logic [N_BITS-1:0]                epc_o,
    output logic [N_BITS-1:0]                ras_top_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count_o,
    output logic                             ret_mispredict_o,
    output logic                             misaligned_o,
    output logic                             ras_overflow_o,
    output logic                             ras_underflow_o
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    logic [N_BITS-1:0] pc_q, pc_d;
    logic [N_BITS-1:0] epc_q, epc_d;
    logic [N_BITS-1:0] ras_q [RAS_DEPTH];
    logic [N_BITS-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, push_ptr, pop_ptr;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mispredict_q, mispredict_d;
    logic              misaligned_q, misaligned_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic [N_BITS-1:0] pc_plus4;
    logic [N_BITS-1:0] branch_target;
    logic [N_BITS-1:0] jump_target;
    logic [N_BITS-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;

    assign pc_plus4      = pc_q + N_BITS'(4);
    assign branch_target = pc_plus4 + {{(N_BITS-18){branch_offset_i[15]}}, branch_offset_i, 2'b00};
    assign jump_target   = {pc_plus4[N_BITS-1:28], jump_target_i, 2'b00};
    assign ras_empty     = (cnt_q == '0);
    assign ras_full      = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_top       = ras_empty ? '0 : ras_q[ptr_q];
    // Pushing past a full stack wraps onto the oldest slot.
    assign push_ptr      = ptr_q + PTR_W'(1);
    assign pop_ptr       = ptr_q - PTR_W'(1);

    // Next-state selection: PC, EPC, RAS and status flags.
    always_comb begin
        pc_d         = pc_q;
        epc_d        = epc_q;
        ras_d        = ras_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        mispredict_d = 1'b0;
        misaligned_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (exception_i) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
        end else if (!stall_i) begin
            if (jr_i && (jr_addr_i[1:0] != 2'b00)) begin
                pc_d         = EXC_VECTOR;
                epc_d        = pc_q;
                misaligned_d = 1'b1;
            end else if (jr_i) begin
                pc_d = jr_addr_i;
            end else if (jump_i) begin
                pc_d = jump_target;
            end else if (branch_taken_i) begin
                pc_d = branch_target;
            end else begin
                pc_d = pc_plus4;
            end

            // Return prediction always compares against the pre-update top.
            if (call_i && ret_i) begin
                if (ras_empty) begin
                    ras_d[push_ptr] = pc_plus4;
                    ptr_d           = push_ptr;
                    cnt_d           = CNT_W'(1);
                    underflow_d     = 1'b1;
                end else begin
                    ras_d[ptr_q] = pc_plus4;
                    mispredict_d = (jr_addr_i != ras_top);
                end
            end else if (call_i) begin
                ras_d[push_ptr] = pc_plus4;
                ptr_d           = push_ptr;
                if (ras_full) begin
                    overflow_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (ret_i) begin
                if (ras_empty) begin
                    underflow_d  = 1'b1;
                    mispredict_d = 1'b1;
                end else begin
                    mispredict_d = (jr_addr_i != ras_top);
                    ptr_d        = pop_ptr;
                    cnt_d        = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // State register, updated on the falling edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
            ptr_q        <= '0;
            cnt_q        <= '0;
            mispredict_q <= 1'b0;
            misaligned_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            ras_q        <= ras_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            mispredict_q <= mispredict_d;
            misaligned_q <= misaligned_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    assign pc_value_o       = pc_q;
    assign pc_plus4_o       = pc_plus4;
    assign epc_o            = epc_q;
    assign ras_top_o        = ras_top;
    assign ras_count_o      = cnt_q;
    assign ret_mispredict_o = mispredict_q;
    assign misaligned_o     = misaligned_q;
    assign ras_overflow_o   = overflow_q;
    assign ras_underflow_o  = underflow_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the single-cycle MIPS core.
- Selects and registers the next PC from these sources: sequential, branch, jump, jump-register or exception vector.
- Supports stall, captures the exception PC (EPC), and keeps a small return-address stack (RAS) that checks `jr $ra` targets.
- Sits between the control/branch logic and instruction memory.

Parameters:
- N_BITS, 32, PC width (must be ≥ 32).
- RESET_VECTOR, 32'h00400000, PC value at reset.
- EXC_VECTOR, 32'h80000180, PC loaded on exception or misaligned jump-register.
- RAS_DEPTH, 4, return-address stack entries (≥ 2, power of two).

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-high.
- stall_i  in  1  hold PC and RAS.
- branch_taken_i  in  1  take branch.
- branch_offset_i  in  16  signed word offset.
- jump_i  in  1  j/jal.
- jump_target_i  in  26  instr_index field.
- jr_i  in  1  jump-register.
- jr_addr_i  in  N_BITS  register target.
- call_i  in  1  jal/jalr; push pc+4.
- ret_i  in  1  jr $ra; pop and compare.
- exception_i  in  1  trap request.
- pc_value_o  out  N_BITS  current PC.
- pc_plus4_o  out  N_BITS  pc_value_o+4, combinational.
- epc_o  out  N_BITS  PC of last exception.
- ras_top_o  out  N_BITS  top of RAS, 0 when empty.
- ras_count_o  out  $clog2(RAS_DEPTH+1)  valid entries.
- ret_mispredict_o  out  1  one-cycle pulse.
- misaligned_o  out  1  one-cycle pulse.
- ras_overflow_o  out  1  sticky.
- ras_underflow_o  out  1  sticky.

Behaviour:
- **Reset:** reset=1 forces, immediately and independent of clk:
  - pc_value_o=RESET_VECTOR;
  - epc_o=0; RAS entries=0; ras_count_o=0;
  - all flags 0.
- **Reset mid-operation:** discards any pending update. First falling edge after reset deasserts applies normal selection.
- **Arithmetic:** all PC arithmetic is modulo 2^N_BITS.
  - pc_plus4 = pc+4.
  - branch target = pc_plus4 + (sign_extend(offset) << 2).
  - jump target = {pc_plus4[N_BITS-1:28], jump_target_i, 2'b00}.
- **Next-PC priority per falling edge:**
  1. exception_i → EXC_VECTOR; epc_o <= pc_value_o. Overrides stall.
  2. stall_i → hold PC, RAS and epc_o. Pulses drop to 0.
  3. jr_i with jr_addr_i[1:0]≠0 → EXC_VECTOR; epc_o <= pc_value_o; misaligned_o=1 for one cycle.
  4. jr_i → jr_addr_i.
  5. jump_i → jump target.
  6. branch_taken_i → branch target.
  7. Otherwise pc_plus4.
- **RAS updates:** only when neither stall nor exception is active.
  - call_i alone: push pc_plus4 and increment count.
    - If full, overwrite the oldest entry (circular); count stays RAS_DEPTH; ras_overflow_o <= 1.
  - ret_i alone: pop the top and decrement count.
    - If jr_addr_i ≠ popped value → ret_mispredict_o pulse.
    - If empty: no pop, count stays 0, ras_underflow_o <= 1, ret_mispredict_o pulse.
  - call_i & ret_i together: top is replaced by pc_plus4; count unchanged.
    - If empty: acts as a push; ras_underflow_o <= 1.
  - The comparison uses the pre-update top.
- **Sticky flags:** cleared only by reset.
- **Misaligned case:** the misaligned jr still pops the RAS if ret_i is set.
- **Latency:** one falling edge from input to pc_value_o. ras_top_o and ras_count_o reflect registered state.

Test Plan:
- **Reset:** assert reset mid-cycle with pc=0x00400010 → pc_value_o=0x00400000 immediately, before any clock edge; count=0; flags 0.
- **Sequential and branch:** 3 edges from reset → pc=0x0040000C. Then branch_taken_i with offset=16'hFFFE → pc=0x00400008.
- **Jump and stall priority:** jump_target_i=26'h0100020 → pc=0x00400080. Then stall_i with jump_i=1 → PC holds. Then exception_i with stall_i=1 → pc=0x80000180, epc_o=0x00400080.
- **Call/return:** call at pc=0x00400000 pushes 0x00400004. ret_i with jr_addr_i=0x00400004 → count 0, no mispredict. Repeat with jr_addr_i=0x00400008 → mispredict pulse for one cycle only.
- **RAS overflow:** RAS_DEPTH+1 calls → count=4, overflow=1, oldest entry lost. 5 rets → last ret sets underflow=1 and pulses mispredict.
- **Misaligned jr:** jr_addr_i=0x00400002 → pc=0x80000180, misaligned_o pulse, epc_o=faulting PC.
